// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and S-box tables for the SubBytes engine.
// Purely declarative: no logic, no latency of its own.
// Inverse table exists only when AES_SUBBYTES_INV_EN is defined.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sb_state_e;

    // Forward S-box, indexed by input byte.
    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef AES_SUBBYTES_INV_EN
    // Inverse S-box, indexed by input byte.
    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte of AES substitution (forward, or forward/inverse under AES_SUBBYTES_INV_EN).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    input  logic       inv_i,
    output logic [7:0] byte_o
);

`ifdef AES_SUBBYTES_INV_EN
    // Both tables looked up in parallel; mode picks which image leaves the lane.
    always_comb begin
        byte_o = inv_i ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];
    end
`else
    // Forward-only build: the mode input has no effect.
    logic unused_inv;
    assign unused_inv = inv_i;

    // Forward table lookup.
    always_comb begin
        byte_o = SBOX_FWD[byte_i];
    end
`endif

endmodule

// File: rtl/aes_subbytes_seq.sv
// Sequential AES SubBytes: LANES bytes per clock, in-place on a 128-bit working register.
// Latency: out_valid rises 16/LANES cycles after accept; back-to-back rate one state per 16/LANES+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE&out_ready. Macro: AES_SUBBYTES_INV_EN.
module aes_subbytes_seq
    import aes_pkg::*;
#(
    // Legal values: 1, 2, 4, 8, 16.
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    // The 4-bit byte index wraps naturally, so a step of 16 truncates to 0.
    localparam logic [3:0] IDX_STEP = 4'(LANES);
    localparam logic [3:0] IDX_LAST = 4'(BYTES - LANES);

    sb_state_e          state_q, state_d;
    logic [STATE_W-1:0] work_q, work_d;
    logic [3:0]         idx_q, idx_d;
    logic               accept;
    logic               lane_inv;

    logic [3:0]         lane_pos [LANES];
    logic [7:0]         lane_in  [LANES];
    logic [7:0]         lane_out [LANES];

    assign accept = in_valid & in_ready;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a new state may be taken in the same cycle the old result leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; out_ready reaches in_ready only through DONE.
    always_comb begin
        in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN);
    end

    // ---------------------------------------------------------------
    // Mode register
    // ---------------------------------------------------------------

`ifdef AES_SUBBYTES_INV_EN
    logic inv_q, inv_d;

    // Mode sampled at accept and held for the whole state.
    always_comb begin
        inv_d = accept ? in_inv : inv_q;
    end

    // Mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign lane_inv = inv_q;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign lane_inv      = 1'b0;
`endif

    // ---------------------------------------------------------------
    // S-box lanes: lane g works on byte idx+g of the working register
    // ---------------------------------------------------------------

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_pos[g] = idx_q + 4'(g);
        assign lane_in[g]  = work_q[{lane_pos[g], 3'b000} +: 8];

        aes_sbox_lane u_lane (
            .byte_i (lane_in[g]),
            .inv_i  (lane_inv),
            .byte_o (lane_out[g])
        );
    end

    // ---------------------------------------------------------------
    // Working register and byte index
    // ---------------------------------------------------------------

    // Load on accept; in RUN overwrite the current group in place and advance the index.
    always_comb begin
        work_d = work_q;
        idx_d  = idx_q;
        if (accept) begin
            work_d = in_data;
            idx_d  = 4'd0;
        end else if (state_q == RUN) begin
            for (int g = 0; g < LANES; g++) begin
                work_d[{lane_pos[g], 3'b000} +: 8] = lane_out[g];
            end
            idx_d = idx_q + IDX_STEP;
        end
    end

    // Datapath registers; reset discards any in-flight state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q <= '0;
            idx_q  <= 4'd0;
        end else begin
            work_q <= work_d;
            idx_q  <= idx_d;
        end
    end

    // Result is the working register itself, so it persists after the handshake.
    assign out_data = work_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Directed bench for aes_subbytes_seq: main instance at LANES=4 plus LANES=1/2/8/16 sweep instances.
module tb_aes_subbytes_seq;

    localparam logic [127:0] V_IN    = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] V_FWD   = 128'h63cab7040953d051cd60e0e7ba70e18c;
`ifdef AES_SUBBYTES_INV_EN
    localparam logic [127:0] V_INVEX = 128'h00102030405060708090a0b0c0d0e0f0;
`else
    localparam logic [127:0] V_INVEX = 128'hfb74a9f201ed70d1bdd0e194f451f864;
`endif
    localparam logic [127:0] V_63    = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_inv, out_ready;
    logic         in_ready, out_valid, busy;
    logic [127:0] in_data, out_data;

    logic         sw_valid, sw_out_ready;
    logic [3:0]   sw_in_ready, sw_out_valid, sw_busy;
    logic [127:0] sw_out_data [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_subbytes_seq #(.LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_subbytes_seq #(.LANES(1)) sw1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[0]), .in_data(128'd0),
        .in_inv(1'b0), .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready), .out_data(sw_out_data[0]),
        .busy(sw_busy[0])
    );
    aes_subbytes_seq #(.LANES(2)) sw2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[1]), .in_data(128'd0),
        .in_inv(1'b0), .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready), .out_data(sw_out_data[1]),
        .busy(sw_busy[1])
    );
    aes_subbytes_seq #(.LANES(8)) sw8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[2]), .in_data(128'd0),
        .in_inv(1'b0), .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready), .out_data(sw_out_data[2]),
        .busy(sw_busy[2])
    );
    aes_subbytes_seq #(.LANES(16)) sw16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[3]), .in_data(128'd0),
        .in_inv(1'b0), .out_valid(sw_out_valid[3]), .out_ready(sw_out_ready), .out_data(sw_out_data[3]),
        .busy(sw_busy[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts cycles until out_valid, bounded so a stuck DUT still reaches the summary.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;
    int sw_lat [4];
    int sw_exp [4];
    logic [127:0] sw_res [4];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
        sw_valid = 1'b0; sw_out_ready = 1'b0;
        sw_exp = '{16, 8, 2, 1};
        for (int k = 0; k < 4; k++) begin
            sw_lat[k] = 0;
            sw_res[k] = '0;
        end

        // Reset state
        tick(); tick();
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data",  out_data,        128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_in_ready",  128'(in_ready),  128'd1);
        rst = 1'b0;
        tick();

        // Lane sweep, all-zero input
        sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (sw_out_valid[k] && sw_lat[k] == 0) begin
                    sw_lat[k] = c;
                    sw_res[k] = sw_out_data[k];
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sweep_latency_%0d", k), 128'(sw_lat[k]), 128'(sw_exp[k]));
            check($sformatf("sweep_data_%0d", k), sw_res[k], V_63);
        end

        // Forward, LANES=4
        in_valid = 1'b1; in_data = V_IN; in_inv = 1'b0;
        check("idle_in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0; in_data = '0;
        check("run_busy",     128'(busy),     128'd1);
        check("run_in_ready", 128'(in_ready), 128'd0);
        wait_out(n);
        check("fwd_latency", 128'(n), 128'd4);
        check("fwd_data",    out_data, V_FWD);

        // Backpressure: hold DONE for 5 cycles
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_data",      out_data,        V_FWD);
            check("bp_in_ready",  128'(in_ready),  128'd0);
        end

        // Simultaneous output and input handshake, inverse request
        in_valid = 1'b1; in_data = V_FWD; in_inv = 1'b1; out_ready = 1'b1;
        #1;
        check("dual_in_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_data = '0;
        check("dual_run_valid", 128'(out_valid), 128'd0);
        check("dual_run_busy",  128'(busy),      128'd1);
        wait_out(n);
        check("dual_latency", 128'(n), 128'd4);
        check("inv_data",     out_data, V_INVEX);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_out_valid", 128'(out_valid), 128'd0);
        check("drain_in_ready",  128'(in_ready),  128'd1);
        check("drain_hold_data", out_data,        V_INVEX);

        // Input ignored during RUN
        in_valid = 1'b1; in_data = '0; in_inv = 1'b0;
        tick();
        n = 0;
        while (!out_valid && n < 40) begin
            in_valid = 1'b1;
            in_data  = {4{$urandom}};
            in_inv   = 1'b1;
            check("ign_in_ready", 128'(in_ready), 128'd0);
            tick();
            n++;
        end
        in_valid = 1'b0; in_inv = 1'b0; in_data = '0;
        check("ign_latency", 128'(n), 128'd4);
        check("ign_data",    out_data, V_63);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset two cycles into RUN
        in_valid = 1'b1; in_data = V_IN;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 128'(out_valid), 128'd0);
        check("mrst_out_data",  out_data,        128'd0);
        check("mrst_busy",      128'(busy),      128'd0);
        check("mrst_in_ready",  128'(in_ready),  128'd1);
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1; in_data = V_IN; in_inv = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        check("post_rst_latency", 128'(n), 128'd4);
        check("post_rst_data",    out_data, V_FWD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
